// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch stage
// Purpose: fetch FSM state encoding, next-pc selector encoding, instruction
// field positions shared by fetch_unit, pc_next and fetch_unit_if.
// Ports: none (package).
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_KEEP   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2
    } pc_sel_e;

    localparam int INSTR_W    = 32;
    localparam int OPFUNC_W   = 12;
    localparam int OPFUNC_MSB = 31;
    localparam int OPFUNC_LSB = 20;

    localparam logic [3:0] COND_AL = 4'd14;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus bundle (imem, decode, redirect)
// Purpose: groups the instruction-memory req/ack port, the decode valid/ready
// port and the controller redirect inputs.
// Ports (master = fetch_unit side):
//   out: imem_req, imem_addr, if_valid, if_instr, opfunc, if_pc, link_addr
//   in : imem_ack, imem_rdata, if_ready, pc_src, branch_target
//   link is driven by the controller and consumed by the register file only.
interface fetch_unit_if #(
    parameter int ADDR_W = 32
);
    import cpu_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                if_valid;
    logic                if_ready;
    logic [INSTR_W-1:0]  if_instr;
    logic [OPFUNC_W-1:0] opfunc;
    logic [ADDR_W-1:0]   if_pc;
    logic [ADDR_W-1:0]   link_addr;
    logic                pc_src;
    logic [ADDR_W-1:0]   branch_target;
    logic                link;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, opfunc, if_pc, link_addr,
        input  imem_ack, imem_rdata, if_ready, pc_src, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, opfunc, if_pc, link_addr,
        output imem_ack, imem_rdata, if_ready, pc_src, branch_target, link
    );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// rtl/fetch_unit_pc_next.sv - next program counter selector
// Purpose: combinational choice between pc, pc + 4 and the word-aligned
// branch target.
// Ports:
//   sel           in  selector (keep / increment / branch)
//   pc            in  current program counter
//   branch_target in  redirect address, low two bits dropped
//   pc_inc        out pc + 4, wraps modulo 2^ADDR_W
//   next_pc       out selected next program counter
module pc_next
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  pc_sel_e           sel,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_inc,
    output logic [ADDR_W-1:0] next_pc
);

    assign pc_inc = pc + ADDR_W'(4);

    always_comb begin
        next_pc = pc;
        unique case (sel)
            PC_INC:    next_pc = pc_inc;
            PC_BRANCH: next_pc = branch_target & ~ADDR_W'(3);
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect and drain
// Purpose: owns the program counter, fetches words over imem req/ack, holds
// each instruction for decode under valid/ready and applies redirects.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   bus   fetch_unit_if.master (imem port, decode port, redirect inputs)
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    fetch_state_e        state_q, state_d;
    pc_sel_e             pc_sel;
    logic                capture;
    logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
    // Address of the request on the bus; lets DRAIN keep presenting the old
    // address after pc has already moved to the redirect target.
    logic [ADDR_W-1:0]   addr_q;
    logic [INSTR_W-1:0]  if_instr_q;
    logic [ADDR_W-1:0]   if_pc_q;
    logic [ADDR_W-1:0]   link_q;

    pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .sel           (pc_sel),
        .pc            (pc_q),
        .branch_target (bus.branch_target),
        .pc_inc        (pc_inc),
        .next_pc       (pc_d)
    );

    // Redirect wins over ack and ready in every state.
    always_comb begin
        state_d = state_q;
        pc_sel  = PC_KEEP;
        capture = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
                if (bus.pc_src) pc_sel = PC_BRANCH;
            end
            ST_FETCH: begin
                if (bus.pc_src) begin
                    pc_sel  = PC_BRANCH;
                    // A returning word is dropped; otherwise wait it out.
                    state_d = bus.imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (bus.imem_ack) begin
                    pc_sel  = PC_INC;
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.pc_src) begin
                    pc_sel  = PC_BRANCH;
                    state_d = ST_FETCH;
                end else if (bus.if_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (bus.pc_src) pc_sel = PC_BRANCH;
                if (bus.imem_ack) state_d = ST_FETCH;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            link_q     <= ADDR_W'(4);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == ST_FETCH) addr_q <= pc_q;
            if (capture) begin
                if_instr_q <= bus.imem_rdata;
                if_pc_q    <= pc_q;
                link_q     <= pc_inc;
            end
        end
    end

    assign bus.imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign bus.imem_addr = (state_q == ST_DRAIN) ? addr_q : pc_q;
    assign bus.if_valid  = (state_q == ST_HOLD);
    assign bus.if_instr  = if_instr_q;
    assign bus.opfunc    = if_instr_q[OPFUNC_MSB:OPFUNC_LSB];
    assign bus.if_pc     = if_pc_q;
    assign bus.link_addr = link_q;

endmodule
